// File: rtl/pwm_duty_sequencer.sv
// Memory-mapped duty-cycle streamer feeding a PWM core: period register,
// duty FIFO popped on each carry-out, status flags and a low-watermark interrupt.
module pwm_duty_sequencer #(
    parameter int DEPTH = 16,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  addr,
    input  logic [31:0] wrdata,
    input  logic        write,
    output logic [31:0] rddata,
    input  logic        co,
    output logic [31:0] period,
    output logic [31:0] duty,
    output logic        irq
);

    localparam int PW = LW - 1;

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [LW-1:0] level;
    logic [LW-1:0] level_nxt;
    logic [LW-1:0] thresh;
    logic          en;
    logic          hold;
    logic          irq_en;
    logic          underflow;
    logic          overflow;

    logic          wr_period;
    logic          push_req;
    logic          wr_ctrl;
    logic          wr_thresh;
    logic          flush;
    logic          clr;
    logic          pop_req;
    logic          empty;
    logic          full;
    logic          pop_ok;
    logic          push_ok;
    logic          udf_set;
    logic          ovf_set;

    // A flush swallows any push or pop in the same cycle, including their flags.
    always_comb begin
        wr_period = write && (addr == 2'd0);
        push_req  = write && (addr == 2'd1);
        wr_ctrl   = write && (addr == 2'd2);
        wr_thresh = write && (addr == 2'd3);
        flush     = wr_ctrl && wrdata[4];
        clr       = wr_ctrl && wrdata[3];
        pop_req   = co && en;
        empty     = (level == '0);
        full      = (level == LW'(DEPTH));
        pop_ok    = !flush && pop_req && !empty;
        udf_set   = !flush && pop_req && empty;
        push_ok   = !flush && push_req && (!full || pop_ok);
        ovf_set   = !flush && push_req && full && !pop_ok;
        level_nxt = level;
        if (push_ok && !pop_ok) begin
            level_nxt = level + LW'(1);
        end else if (pop_ok && !push_ok) begin
            level_nxt = level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= wrdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period    <= '0;
            duty      <= '0;
            en        <= 1'b0;
            hold      <= 1'b0;
            irq_en    <= 1'b0;
            thresh    <= '0;
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (wr_period) begin
                period <= wrdata;
            end
            if (wr_ctrl) begin
                en     <= wrdata[0];
                hold   <= wrdata[1];
                irq_en <= wrdata[2];
            end
            if (wr_thresh) begin
                thresh <= wrdata[LW-1:0];
            end
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                level <= '0;
            end else begin
                if (push_ok) begin
                    wptr <= wptr + PW'(1);
                end
                if (pop_ok) begin
                    rptr <= rptr + PW'(1);
                    duty <= mem[rptr];
                end else if (udf_set && !hold) begin
                    duty <= '0;
                end
                level <= level_nxt;
            end
            // A set in the same cycle as a clear wins.
            underflow <= udf_set || (underflow && !clr);
            overflow  <= ovf_set || (overflow && !clr);
            irq       <= irq_en && (underflow || (level <= thresh));
        end
    end

    always_comb begin
        rddata = '0;
        case (addr)
            2'd0: rddata = period;
            2'd1: rddata = duty;
            2'd2: begin
                rddata[0]       = en;
                rddata[1]       = hold;
                rddata[2]       = irq_en;
                rddata[3]       = underflow;
                rddata[4]       = empty;
                rddata[5]       = full;
                rddata[6]       = overflow;
                rddata[8 +: LW] = level;
            end
            default: rddata[LW-1:0] = thresh;
        endcase
    end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer: a vector table for the basic register
// and streaming behaviour, then hand-written sequences for multi-cycle corners.
module tb_pwm_duty_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  addr = '0;
    logic [31:0] wrdata = '0;
    logic        write = 1'b0;
    logic [31:0] rddata;
    logic        co = 1'b0;
    logic [31:0] period;
    logic [31:0] duty;
    logic        irq;

    int compared = 0;
    int mismatched = 0;

    pwm_duty_sequencer #(.DEPTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr   (addr),
        .wrdata (wrdata),
        .write  (write),
        .rddata (rddata),
        .co     (co),
        .period (period),
        .duty   (duty),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          gap;
        logic        wr;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic        co;
        logic [1:0]  raddr;
        logic [31:0] exp_rd;
        logic [31:0] exp_duty;
        logic        exp_irq;
        string       name;
    } vec_t;

    vec_t vecs [16];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
        end
    endtask

    task automatic readReg(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rddata;
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [31:0] d, input logic with_co);
        addr = a;
        wrdata = d;
        write = 1'b1;
        co = with_co;
        @(posedge clk);
        #1;
        write = 1'b0;
        co = 1'b0;
    endtask

    task automatic pulseCo();
        co = 1'b1;
        @(posedge clk);
        #1;
        co = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [31:0] rd;
        idle(v.gap);
        addr = v.waddr;
        wrdata = v.wdata;
        write = v.wr;
        co = v.co;
        @(posedge clk);
        #1;
        write = 1'b0;
        co = 1'b0;
        readReg(v.raddr, rd);
        checkOutput({v.name, "_rd"}, rd, v.exp_rd);
        checkOutput({v.name, "_duty"}, duty, v.exp_duty);
        checkOutput({v.name, "_irq"}, {31'd0, irq}, {31'd0, v.exp_irq});
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;

        vecs[0]  = '{0,  1'b1, 2'd0, 32'd99,       1'b0, 2'd0, 32'd99,    32'd0,  1'b0, "period"};
        vecs[1]  = '{0,  1'b1, 2'd1, 32'd10,       1'b0, 2'd2, 32'h100,   32'd0,  1'b0, "push10"};
        vecs[2]  = '{0,  1'b1, 2'd1, 32'd20,       1'b0, 2'd2, 32'h200,   32'd0,  1'b0, "push20"};
        vecs[3]  = '{0,  1'b1, 2'd1, 32'd30,       1'b0, 2'd2, 32'h300,   32'd0,  1'b0, "push30"};
        vecs[4]  = '{0,  1'b1, 2'd2, 32'd1,        1'b0, 2'd2, 32'h301,   32'd0,  1'b0, "ctrl_en"};
        vecs[5]  = '{20, 1'b0, 2'd0, 32'd0,        1'b1, 2'd1, 32'd10,    32'd10, 1'b0, "co1"};
        vecs[6]  = '{20, 1'b0, 2'd0, 32'd0,        1'b1, 2'd2, 32'h101,   32'd20, 1'b0, "co2"};
        vecs[7]  = '{20, 1'b0, 2'd0, 32'd0,        1'b1, 2'd2, 32'h011,   32'd30, 1'b0, "co3"};
        vecs[8]  = '{0,  1'b0, 2'd0, 32'd0,        1'b1, 2'd2, 32'h019,   32'd0,  1'b0, "udf_zero"};
        vecs[9]  = '{0,  1'b1, 2'd1, 32'd30,       1'b0, 2'd2, 32'h109,   32'd0,  1'b0, "push30b"};
        vecs[10] = '{0,  1'b0, 2'd0, 32'd0,        1'b1, 2'd1, 32'd30,    32'd30, 1'b0, "pop30"};
        vecs[11] = '{0,  1'b1, 2'd2, 32'd3,        1'b0, 2'd2, 32'h01B,   32'd30, 1'b0, "ctrl_hold"};
        vecs[12] = '{0,  1'b0, 2'd0, 32'd0,        1'b1, 2'd2, 32'h01B,   32'd30, 1'b0, "udf_hold"};
        vecs[13] = '{0,  1'b1, 2'd2, 32'h0B,       1'b0, 2'd2, 32'h013,   32'd30, 1'b0, "udf_clr"};
        vecs[14] = '{0,  1'b1, 2'd3, 32'hFFFFFFFF, 1'b0, 2'd3, 32'h1F,    32'd30, 1'b0, "thresh_mask"};
        vecs[15] = '{0,  1'b1, 2'd3, 32'd0,        1'b0, 2'd3, 32'd0,     32'd30, 1'b0, "thresh_zero"};

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        readReg(2'd0, rd);
        checkOutput("rst_period", rd, 32'd0);
        readReg(2'd2, rd);
        checkOutput("rst_status", rd, 32'h10);
        readReg(2'd3, rd);
        checkOutput("rst_thresh", rd, 32'd0);
        checkOutput("rst_duty", duty, 32'd0);
        checkOutput("rst_irq", {31'd0, irq}, 32'd0);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Overflow: 17 pushes into a 16-deep FIFO with en=1, hold=1.
        for (int i = 1; i <= 17; i++) busWrite(2'd1, 32'(i), 1'b0);
        readReg(2'd2, rd);
        checkOutput("ovf_status", rd, 32'h1063);
        checkOutput("ovf_period", period, 32'd99);

        // Full FIFO: push and pop together keep the level and ordering.
        busWrite(2'd1, 32'd100, 1'b1);
        checkOutput("full_pushpop_duty", duty, 32'd1);
        readReg(2'd2, rd);
        checkOutput("full_pushpop_status", rd, 32'h1063);
        for (int i = 0; i < 16; i++) begin
            pulseCo();
            checkOutput("ovf_drain", duty, (i < 15) ? 32'(i + 2) : 32'd100);
        end
        readReg(2'd2, rd);
        checkOutput("drained_status", rd, 32'h053);
        busWrite(2'd2, 32'h0B, 1'b0);
        readReg(2'd2, rd);
        checkOutput("ovf_clr", rd, 32'h013);

        // Empty FIFO: push and pop together underflow but still store the word.
        busWrite(2'd1, 32'd5, 1'b1);
        checkOutput("empty_pushpop_duty", duty, 32'd100);
        readReg(2'd2, rd);
        checkOutput("empty_pushpop_status", rd, 32'h10B);
        pulseCo();
        checkOutput("bypass_duty", duty, 32'd5);

        // Clear-write colliding with a new underflow: the set wins.
        busWrite(2'd2, 32'h0B, 1'b1);
        readReg(2'd2, rd);
        checkOutput("clr_vs_set", rd, 32'h01B);
        busWrite(2'd2, 32'h0B, 1'b0);
        readReg(2'd2, rd);
        checkOutput("clr_again", rd, 32'h013);

        // Low-watermark interrupt.
        busWrite(2'd3, 32'd2, 1'b0);
        busWrite(2'd2, 32'd5, 1'b0);
        for (int i = 11; i <= 14; i++) busWrite(2'd1, 32'(i), 1'b0);
        checkOutput("irq_above", {31'd0, irq}, 32'd0);
        pulseCo();
        pulseCo();
        checkOutput("irq_latency", {31'd0, irq}, 32'd0);
        checkOutput("irq_pop_duty", duty, 32'd12);
        idle(1);
        checkOutput("irq_at_thresh", {31'd0, irq}, 32'd1);
        busWrite(2'd2, 32'd1, 1'b0);
        idle(1);
        checkOutput("irq_disabled", {31'd0, irq}, 32'd0);

        // Flush with a coincident co: no pop, no flag, duty kept.
        for (int i = 21; i <= 23; i++) busWrite(2'd1, 32'(i), 1'b0);
        busWrite(2'd2, 32'h11, 1'b1);
        readReg(2'd2, rd);
        checkOutput("flush_status", rd, 32'h011);
        checkOutput("flush_duty", duty, 32'd12);

        // Reset mid-stream with irq asserted.
        busWrite(2'd2, 32'd5, 1'b0);
        busWrite(2'd1, 32'd7, 1'b0);
        pulseCo();
        checkOutput("pre_rst_duty", duty, 32'd7);
        checkOutput("pre_rst_irq", {31'd0, irq}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_period", period, 32'd0);
        checkOutput("midrst_duty", duty, 32'd0);
        checkOutput("midrst_irq", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        readReg(2'd2, rd);
        checkOutput("midrst_status", rd, 32'h10);
        readReg(2'd3, rd);
        checkOutput("midrst_thresh", rd, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
